// File: rtl/proc_core_pkg.sv
// Shared constants and helpers for the multi-channel convolution core.
package proc_core_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam int PIPE_STAGES = 2;  // registered read + registered product

  function automatic int acc_width(input int dw, input int max_klen);
    return 2 * dw + $clog2(max_klen);
  endfunction

  // Clamp a sign-extended value into a signed ow-bit range; caller truncates.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned ow);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/proc_core_mc_if.sv
// Config, sample-input and result handshake bundle of the convolution core.
interface proc_core_mc_if #(
  parameter int DW       = 16,
  parameter int NCH      = 4,
  parameter int MAX_KLEN = 16,
  parameter int OUT_W    = 16,
  parameter int ACC_W    = 2*DW + $clog2(MAX_KLEN)
);
  localparam int KW = $clog2(MAX_KLEN+1);
  localparam int SW = $clog2(ACC_W);

  logic                                  conf_enable_i;
  logic [KW-1:0]                         conf_klen_i;
  logic [KW-1:0]                         conf_stride_i;
  logic [SW-1:0]                         conf_shift_i;
  logic                                  flush_i;
  logic [NCH-1:0][MAX_KLEN-1:0][DW-1:0]  weights_i;
  logic [DW-1:0]                         data_i;
  logic                                  data_valid_i;
  logic                                  data_ready_o;
  logic [NCH-1:0][OUT_W-1:0]             res_o;
  logic                                  res_valid_o;
  logic                                  res_ready_i;

  modport master (
    output conf_enable_i, conf_klen_i, conf_stride_i, conf_shift_i, flush_i,
           weights_i, data_i, data_valid_i, res_ready_i,
    input  data_ready_o, res_o, res_valid_o
  );

  modport slave (
    input  conf_enable_i, conf_klen_i, conf_stride_i, conf_shift_i, flush_i,
           weights_i, data_i, data_valid_i, res_ready_i,
    output data_ready_o, res_o, res_valid_o
  );
endinterface

// File: rtl/proc_databuf.sv
// Circular sample store: simple dual-port RAM, synchronous write, registered read.
module proc_databuf #(
  parameter int DW    = 16,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/proc_core_mc.sv
// Sliding-window dot products of a sample stream against NCH weight sets,
// with stride, shift/saturate and valid/ready on both sides.
module proc_core_mc import proc_core_pkg::*; #(
  parameter int DW        = 16,
  parameter int NCH       = 4,
  parameter int MAX_KLEN  = 16,
  parameter int BUF_DEPTH = 32,
  parameter int OUT_W     = 16,
  parameter int ACC_W     = 2*DW + $clog2(MAX_KLEN)
) (
  input  logic          clock,
  input  logic          reset,
  proc_core_mc_if.slave bus
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = AW + 1;
  localparam int KW = $clog2(MAX_KLEN+1);
  localparam int TW = $clog2(MAX_KLEN);
  localparam int PRW = 2*DW;

  logic [PW-1:0]          wr_ptr, rd_base, occ;
  logic [1:0]             state;
  logic [KW-1:0]          tap;
  logic [PIPE_STAGES:1]   vld_pipe;
  logic [TW-1:0]          rd_tap;
  logic                   rd_first, pr_first;
  logic [DW-1:0]          rdata;
  logic                   en, wr;

  assign en               = bus.conf_enable_i;
  assign occ              = wr_ptr - rd_base;
  assign bus.data_ready_o = en & ~bus.flush_i & ~reset & (occ < PW'(BUF_DEPTH));
  assign wr               = bus.data_valid_i & bus.data_ready_o;
  assign bus.res_valid_o  = (state == S_OUT);

  // Read enable follows the stall so the read stage freezes with the pipeline.
  proc_databuf #(.DW(DW), .DEPTH(BUF_DEPTH)) u_buf (
    .clock (clock),
    .we    (wr),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.data_i),
    .re    (en),
    .raddr (AW'(rd_base + PW'(tap))),
    .rdata (rdata)
  );

  always_ff @(posedge clock) begin
    if (reset || bus.flush_i) begin
      wr_ptr   <= '0;
      rd_base  <= '0;
      state    <= S_IDLE;
      tap      <= '0;
      vld_pipe <= '0;
      rd_tap   <= '0;
      rd_first <= 1'b0;
      pr_first <= 1'b0;
    end else if (en) begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      vld_pipe <= {vld_pipe[PIPE_STAGES-1:1], state == S_MAC};
      rd_tap   <= TW'(tap);
      rd_first <= (tap == '0);
      pr_first <= rd_first;
      case (state)
        S_IDLE: if (occ >= PW'(bus.conf_klen_i)) begin
          state <= S_MAC;
          tap   <= '0;
        end
        S_MAC: if (tap == bus.conf_klen_i - KW'(1)) begin
          state <= S_DRAIN;
          tap   <= '0;
        end else tap <= tap + 1'b1;
        // two cycles let the last tap clear the read and multiply stages
        S_DRAIN: if (tap == KW'(1)) state <= S_OUT;
                 else tap <= tap + 1'b1;
        default: if (bus.res_ready_i) begin
          rd_base <= rd_base + PW'(bus.conf_stride_i);
          state   <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic signed [PRW-1:0]   prod;
    logic signed [ACC_W-1:0] prod_x, acc, sh;

    assign prod_x = {{(ACC_W-PRW){prod[PRW-1]}}, prod};

    always_ff @(posedge clock) begin
      if (reset || bus.flush_i) begin
        prod <= '0;
        acc  <= '0;
      end else if (en) begin
        if (vld_pipe[1]) prod <= $signed(rdata) * $signed(bus.weights_i[ch][rd_tap]);
        if (vld_pipe[2]) acc  <= pr_first ? prod_x : acc + prod_x;
      end
    end

    assign sh = acc >>> bus.conf_shift_i;
    assign bus.res_o[ch] = OUT_W'(saturate({{(64-ACC_W){sh[ACC_W-1]}}, sh}, OUT_W));
  end
endmodule

// File: tb/tb_proc_core_mc.sv
// Directed bench for proc_core_mc: vector table plus multi-cycle corner sequences.
module tb_proc_core_mc;
  import proc_core_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  proc_core_mc_if #(.DW(16), .NCH(2), .MAX_KLEN(16), .OUT_W(16)) ifc ();

  proc_core_mc #(.DW(16), .NCH(2), .MAX_KLEN(16), .BUF_DEPTH(32), .OUT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  typedef struct packed {
    int               klen, stride, shift, nd, d0, dstep;
    logic [7:0][15:0] w0, w1;
    int               nexp;
    logic [3:0][15:0] e0, e1;
    int               occ_end;
  } vec_t;

  int errors = 0, checks = 0;
  logic [15:0] got0[$], got1[$];
  int mac_c, valid_c, probe_occ;
  logic probe_ready;
  bit unstable;

  function automatic logic [7:0][15:0] w8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][15:0] r;
    r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
    r[4] = 16'(a4); r[5] = 16'(a5); r[6] = 16'(a6); r[7] = 16'(a7);
    return r;
  endfunction

  function automatic logic [3:0][15:0] e4(input int a0, a1, a2, a3);
    logic [3:0][15:0] r;
    r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_flush();
    ifc.flush_i = 1'b1;
    @(posedge clock); #1;
    ifc.flush_i = 1'b0;
  endtask

  task automatic set_cfg(input int klen, stride, shift, input logic [7:0][15:0] w0, w1);
    ifc.conf_klen_i   = 5'(klen);
    ifc.conf_stride_i = 5'(stride);
    ifc.conf_shift_i  = 6'(shift);
    ifc.weights_i     = '0;
    for (int k = 0; k < 8; k++) begin
      ifc.weights_i[0][k] = w0[k];
      ifc.weights_i[1][k] = w1[k];
    end
  endtask

  // Cycle-stepped driver/collector; inputs change 1 after posedge, sampled on negedge.
  task automatic run(input int klen, stride, shift, input logic [7:0][15:0] w0, w1,
                     input int nd, d0, dstep, hold, stall_at, stall_len, probe_c, ncyc);
    int idx;
    bit pend;
    logic [1:0][15:0] prev;
    set_cfg(klen, stride, shift, w0, w1);
    got0.delete(); got1.delete();
    mac_c = -1; valid_c = -1; unstable = 0; idx = 0; pend = 0; prev = '0;
    for (int c = 0; c < ncyc; c++) begin
      ifc.data_valid_i  = (idx < nd);
      ifc.data_i        = 16'(d0 + idx * dstep);
      ifc.res_ready_i   = (c >= hold);
      ifc.conf_enable_i = !(stall_at >= 0 && c >= stall_at && c < stall_at + stall_len);
      @(negedge clock);
      if (mac_c < 0 && dut.state == S_MAC) mac_c = c;
      if (valid_c < 0 && ifc.res_valid_o) valid_c = c;
      if (c == probe_c) begin
        probe_ready = ifc.data_ready_o;
        probe_occ   = int'(dut.occ);
      end
      if (pend && ifc.res_valid_o && ifc.res_o !== prev) unstable = 1;
      pend = ifc.res_valid_o && !(ifc.res_ready_i && ifc.conf_enable_i);
      prev = ifc.res_o;
      if (ifc.res_valid_o && ifc.res_ready_i && ifc.conf_enable_i) begin
        got0.push_back(ifc.res_o[0]);
        got1.push_back(ifc.res_o[1]);
      end
      if (ifc.data_valid_i && ifc.data_ready_o) idx++;
      @(posedge clock); #1;
    end
    ifc.data_valid_i  = 1'b0;
    ifc.res_ready_i   = 1'b0;
    ifc.conf_enable_i = 1'b1;
  endtask

  function automatic longint res_at(input int ch, input int j);
    if (ch == 0) return (j < got0.size()) ? longint'($signed(got0[j])) : 99999;
    return (j < got1.size()) ? longint'($signed(got1[j])) : 99999;
  endfunction

  // Reset or flush while a window is mid-MAC with 6 samples buffered.
  task automatic mid_clear(input bit use_reset);
    int idx;
    bit found;
    string tag;
    tag = use_reset ? "rst" : "flush";
    do_flush();
    set_cfg(4, 1, 0, w8(1,1,1,1,0,0,0,0), w8(1,2,3,4,0,0,0,0));
    ifc.res_ready_i = 1'b1;
    idx = 0; found = 0;
    for (int c = 0; c < 30; c++) begin
      ifc.data_valid_i = (idx < 6);
      ifc.data_i       = 16'(idx + 1);
      @(negedge clock);
      if (dut.state == S_MAC && int'(dut.occ) == 6) begin
        found = 1;
        break;
      end
      if (ifc.data_valid_i && ifc.data_ready_o) idx++;
      @(posedge clock); #1;
    end
    chk({tag, " reached MAC occ6"}, longint'(found), 1);
    @(posedge clock); #1;
    ifc.data_valid_i = 1'b0;
    if (use_reset) reset = 1'b1; else ifc.flush_i = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; ifc.flush_i = 1'b0;
    @(negedge clock);
    chk({tag, " res_valid"}, longint'(ifc.res_valid_o), 0);
    chk({tag, " occ"}, longint'(dut.occ), 0);
    chk({tag, " state"}, longint'(dut.state), longint'(S_IDLE));
    @(posedge clock); #1;
    run(3, 1, 0, w8(1,1,1,0,0,0,0,0), w8(1,2,3,0,0,0,0,0), 3, 1, 1, 0, -1, 0, -1, 30);
    chk({tag, " fresh count"}, longint'(got0.size()), 1);
    chk({tag, " fresh ch0"}, res_at(0, 0), 6);
  endtask

  vec_t tbl[6];

  initial begin
    int v0;
    tbl[0] = '{3, 1, 0, 5, 1, 1, w8(1,1,1,0,0,0,0,0), w8(1,2,3,0,0,0,0,0),
               3, e4(6,9,12,0), e4(14,20,26,0), 2};
    tbl[1] = '{3, 2, 0, 5, 1, 1, w8(1,1,1,0,0,0,0,0), w8(1,2,3,0,0,0,0,0),
               2, e4(6,12,0,0), e4(14,26,0,0), 1};
    tbl[2] = '{8, 1, 0, 8, 32767, 0, w8(32767,32767,32767,32767,32767,32767,32767,32767),
               w8(32767,32767,32767,32767,32767,32767,32767,32767),
               1, e4(32767,0,0,0), e4(32767,0,0,0), 7};
    tbl[3] = '{8, 1, 18, 8, 32767, 0, w8(32767,32767,32767,32767,32767,32767,32767,32767),
               w8(32767,32767,32767,32767,32767,32767,32767,32767),
               1, e4(32766,0,0,0), e4(32766,0,0,0), 7};
    tbl[4] = '{8, 1, 0, 8, -32768, 0, w8(32767,32767,32767,32767,32767,32767,32767,32767),
               w8(32767,32767,32767,32767,32767,32767,32767,32767),
               1, e4(-32768,0,0,0), e4(-32768,0,0,0), 7};
    tbl[5] = '{1, 1, 1, 2, -3, 8, w8(1,0,0,0,0,0,0,0), w8(3,0,0,0,0,0,0,0),
               2, e4(-2,2,0,0), e4(-5,7,0,0), 0};

    reset = 1'b1;
    ifc.conf_enable_i = 1'b1;
    ifc.flush_i       = 1'b0;
    ifc.data_valid_i  = 1'b1;
    ifc.data_i        = 16'd7;
    ifc.res_ready_i   = 1'b0;
    set_cfg(3, 1, 0, '0, '0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset data_ready", longint'(ifc.data_ready_o), 0);
    chk("reset res_valid", longint'(ifc.res_valid_o), 0);
    chk("reset res_o", longint'(ifc.res_o), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    ifc.data_valid_i = 1'b0;
    @(negedge clock);
    chk("post-reset occ", longint'(dut.occ), 0);
    chk("post-reset state", longint'(dut.state), longint'(S_IDLE));
    @(posedge clock); #1;

    for (int i = 0; i < 6; i++) begin
      do_flush();
      run(tbl[i].klen, tbl[i].stride, tbl[i].shift, tbl[i].w0, tbl[i].w1,
          tbl[i].nd, tbl[i].d0, tbl[i].dstep, 0, -1, 0, -1, 60);
      chk($sformatf("v%0d count", i), longint'(got0.size()), longint'(tbl[i].nexp));
      for (int j = 0; j < tbl[i].nexp; j++) begin
        chk($sformatf("v%0d ch0 r%0d", i, j), res_at(0, j), longint'($signed(tbl[i].e0[j])));
        chk($sformatf("v%0d ch1 r%0d", i, j), res_at(1, j), longint'($signed(tbl[i].e1[j])));
      end
      chk($sformatf("v%0d occ end", i), longint'(dut.occ), longint'(tbl[i].occ_end));
    end

    // Backpressure: results blocked for 40 cycles while 1..40 streams in.
    do_flush();
    run(3, 1, 0, w8(1,1,1,0,0,0,0,0), w8(1,2,3,0,0,0,0,0), 40, 1, 1, 40, -1, 0, 39, 360);
    chk("bp data_ready full", longint'(probe_ready), 0);
    chk("bp occ full", longint'(probe_occ), 32);
    chk("bp res_o held", longint'(unstable), 0);
    chk("bp count", longint'(got0.size()), 38);
    for (int k = 0; k < 38; k++) begin
      chk($sformatf("bp ch0 w%0d", k), res_at(0, k), 3 * k + 6);
      chk($sformatf("bp ch1 w%0d", k), res_at(1, k), 6 * k + 14);
    end
    chk("bp occ end", longint'(dut.occ), 2);

    // Stall: unstalled latency, then 5-cycle enable drop mid-MAC.
    do_flush();
    run(3, 1, 0, w8(1,1,1,0,0,0,0,0), w8(1,2,3,0,0,0,0,0), 3, 1, 1, 0, -1, 0, -1, 40);
    v0 = valid_c;
    chk("nostall latency", longint'(valid_c - mac_c), 5);
    chk("nostall ch0", res_at(0, 0), 6);
    do_flush();
    run(3, 1, 0, w8(1,1,1,0,0,0,0,0), w8(1,2,3,0,0,0,0,0), 3, 1, 1, 0, 5, 5, -1, 50);
    chk("stall delay", longint'(valid_c - v0), 5);
    chk("stall latency", longint'(valid_c - mac_c), 10);
    chk("stall count", longint'(got0.size()), 1);
    chk("stall ch0", res_at(0, 0), 6);
    chk("stall ch1", res_at(1, 0), 14);

    mid_clear(1'b1);
    mid_clear(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
